// File: rtl/alu_pipe.sv
// Handshaked ALU: ADD/SUB/logic/shift in 1 cycle, MUL/DIV iterate over WIDTH cycles.
// Result and {O,C,N,Z} are held in DONE until taken; a same-cycle accept keeps back-to-back throughput.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [3:0]       i_opcode,
  input  logic [WIDTH-1:0] i_src1,
  input  logic [WIDTH-1:0] i_src2,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out,
  output logic [3:0]       o_flags,
  output logic             o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7;
  localparam logic [3:0] OP_SLA = 4'h8, OP_SRA = 4'h9, OP_SLL = 4'hA, OP_SRL = 4'hB;

  state_t           r_state, w_next;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_acc, r_q, r_opb;
  logic [WIDTH-1:0] r_out;
  logic [3:0]       r_flags;

  logic             w_accept, w_last;
  logic [WIDTH:0]   w_sum, w_dif, w_shl, w_srl, w_sra;
  logic             w_big;
  logic [SHW-1:0]   w_amt;
  logic [WIDTH-1:0] w_s_res;
  logic             w_s_c, w_s_o;
  logic [WIDTH:0]   w_madd, w_dsh;
  logic             w_dge;
  logic [WIDTH-1:0] w_it_acc, w_it_q;
  logic [WIDTH-1:0] w_ld_res;
  logic             w_ld_c, w_ld_o;
  logic [3:0]       w_ld_flags;

  assign o_in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & i_out_ready);
  assign o_out_valid = (r_state == S_DONE);
  assign o_busy      = (r_state == S_MUL) | (r_state == S_DIV);
  assign o_out       = r_out;
  assign o_flags     = r_flags;
  assign w_accept    = i_in_valid & o_in_ready;
  assign w_last      = o_busy & (r_cnt == SHW'(WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          if (i_opcode == OP_MUL)      w_next = S_MUL;
          else if (i_opcode == OP_DIV) w_next = S_DIV;
          else                         w_next = S_DONE;
        end else if ((r_state == S_DONE) && i_out_ready) begin
          w_next = S_IDLE;
        end
      end
      S_MUL, S_DIV: if (w_last) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Shifts carry one extra bit so the last bit shifted out lands in a fixed position.
  assign w_sum = {1'b0, i_src1} + {1'b0, i_src2};
  assign w_dif = {1'b0, i_src1} - {1'b0, i_src2};
  assign w_big = |i_src2[WIDTH-1:SHW];
  assign w_amt = i_src2[SHW-1:0];
  assign w_shl = {1'b0, i_src1} << w_amt;
  assign w_srl = {i_src1, 1'b0} >> w_amt;
  assign w_sra = $signed({i_src1, 1'b0}) >>> w_amt;

  always_comb begin
    w_s_res = '0;
    w_s_c   = 1'b0;
    w_s_o   = 1'b0;
    case (i_opcode)
      OP_ADD: begin
        w_s_res = w_sum[WIDTH-1:0];
        w_s_c   = w_sum[WIDTH];
        w_s_o   = (i_src1[WIDTH-1] == i_src2[WIDTH-1]) & (w_sum[WIDTH-1] != i_src1[WIDTH-1]);
      end
      OP_SUB: begin
        w_s_res = w_dif[WIDTH-1:0];
        w_s_c   = w_dif[WIDTH];
        w_s_o   = (i_src1[WIDTH-1] != i_src2[WIDTH-1]) & (w_dif[WIDTH-1] != i_src1[WIDTH-1]);
      end
      OP_AND: w_s_res = i_src1 & i_src2;
      OP_OR:  w_s_res = i_src1 | i_src2;
      OP_XOR: w_s_res = i_src1 ^ i_src2;
      OP_NOT: w_s_res = ~i_src2;
      OP_SLA, OP_SLL: begin
        w_s_res = w_big ? '0 : w_shl[WIDTH-1:0];
        w_s_c   = ~w_big & w_shl[WIDTH];
      end
      OP_SRA: begin
        w_s_res = w_big ? {WIDTH{i_src1[WIDTH-1]}} : w_sra[WIDTH:1];
        w_s_c   = ~w_big & w_sra[0];
      end
      OP_SRL: begin
        w_s_res = w_big ? '0 : w_srl[WIDTH:1];
        w_s_c   = ~w_big & w_srl[0];
      end
      default: ;
    endcase
  end

  // MUL: r_acc:r_q is the product shifting right. DIV: r_acc is the remainder, r_q the dividend/quotient.
  assign w_madd   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opb} : '0);
  assign w_dsh    = {r_acc, r_q[WIDTH-1]};
  assign w_dge    = (w_dsh >= {1'b0, r_opb});
  assign w_it_acc = (r_state == S_DIV) ? (w_dge ? WIDTH'(w_dsh - {1'b0, r_opb}) : w_dsh[WIDTH-1:0])
                                       : w_madd[WIDTH:1];
  assign w_it_q   = (r_state == S_DIV) ? {r_q[WIDTH-2:0], w_dge} : {w_madd[0], r_q[WIDTH-1:1]};

  always_comb begin
    w_ld_res = w_s_res;
    w_ld_c   = w_s_c;
    w_ld_o   = w_s_o;
    if (r_state == S_MUL) begin
      w_ld_res = w_it_q;
      w_ld_c   = |w_it_acc;
      w_ld_o   = |w_it_acc;
    end else if (r_state == S_DIV) begin
      w_ld_res = (r_opb == '0) ? '1 : w_it_q;
      w_ld_c   = 1'b0;
      w_ld_o   = (r_opb == '0);
    end
  end

  assign w_ld_flags = {w_ld_o, w_ld_c, w_ld_res[WIDTH-1], ~|w_ld_res};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_opb   <= '0;
      r_out   <= '0;
      r_flags <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_acc <= '0;
      if (i_opcode == OP_MUL) begin
        r_q   <= i_src2;
        r_opb <= i_src1;
      end else if (i_opcode == OP_DIV) begin
        r_q   <= i_src1;
        r_opb <= i_src2;
      end else begin
        r_out   <= w_ld_res;
        r_flags <= w_ld_flags;
      end
    end else if (o_busy) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_it_acc;
      r_q   <= w_it_q;
      if (w_last) begin
        r_out   <= w_ld_res;
        r_flags <= w_ld_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboarded bench for alu_pipe: directed corner cases then randomized ops with random backpressure.
module tb_alu_pipe;
  localparam int W = 16;
  localparam longint unsigned MOD = 64'd65536;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    opcode;
  logic [W-1:0]  src1, src2;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out;
  logic [3:0]    flags;
  logic          busy;

  int            n_checks = 0;
  int            n_pass = 0;
  logic [19:0]   sb[$];
  logic          rdy_rand = 1'b0;
  int            last_wait;
  logic          hold = 1'b0;
  logic [19:0]   held;

  alu_pipe #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_opcode(opcode), .i_src1(src1), .i_src2(src2), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_out(out), .o_flags(flags), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
  endtask

  // Reference: plain integer arithmetic on the opcode rules, returns {out, O, C, N, Z}.
  function automatic logic [19:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint unsigned r = 0;
    logic c = 1'b0;
    logic o = 1'b0;
    logic neg;
    logic [15:0] res;
    case (op)
      4'd0: begin r = ua + ub; c = (r >= MOD); r = r % MOD; o = (a[15] == b[15]) && (r[15] != a[15]); end
      4'd1: begin r = (ua + MOD - ub) % MOD; c = (ua < ub); o = (a[15] != b[15]) && (r[15] != a[15]); end
      4'd2: begin r = ua * ub; c = (r >= MOD); o = c; r = r % MOD; end
      4'd3: if (ub == 0) begin r = MOD - 1; o = 1'b1; end else r = ua / ub;
      4'd4: r = ua & ub;
      4'd5: r = ua | ub;
      4'd6: r = ua ^ ub;
      4'd7: r = MOD - 1 - ub;
      4'd8, 4'd10: begin
        if (ub >= W) r = 0;
        else if (ub > 0) begin r = (ua << ub) % MOD; c = ((ua >> (W - ub)) % 2) == 1; end
        else r = ua;
      end
      4'd9, 4'd11: begin
        neg = (op == 4'd9) && a[15];
        if (ub >= W) r = neg ? MOD - 1 : 0;
        else if (ub > 0) begin
          r = ua >> ub;
          if (neg) r = r + MOD - (MOD >> ub);
          c = ((ua >> (ub - 1)) % 2) == 1;
        end else r = ua;
      end
      default: r = 0;
    endcase
    res = r[15:0];
    return {res, o, c, res[15], res == 16'd0};
  endfunction

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [19:0] expv);
    in_valid = 1'b1; opcode = op; src1 = a; src2 = b;
    last_wait = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(expv);
        @(posedge clk); #1;
        last_wait = k;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; opcode = 4'($urandom); src1 = 16'($urandom); src2 = 16'($urandom);
    if (last_wait < 0) begin
      n_checks++;
      $display("FAIL issue_timeout: op %0h not accepted within 100 cycles", op);
    end
  endtask

  task automatic wait_drain();
    logic done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (!out_valid && !busy) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL drain_timeout: out_valid=%0b busy=%0b after 200 cycles", out_valid, busy);
    end
    @(posedge clk); #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (rst || !out_valid) hold = 1'b0;
    else begin
      if (hold) check("hold_stable", {out, flags}, held);
      if (out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got out=%0h flags=%0b, expected no output", out, flags);
        end else check("result", {out, flags}, sb.pop_front());
        hold = 1'b0;
      end else begin
        hold = 1'b1;
        held = {out, flags};
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [15:0] a, b;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; opcode = '0; src1 = '0; src2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {out_valid, busy, flags, out}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    issue(4'd0, 16'h7fff, 16'h0001, {16'h8000, 4'b1010});
    @(negedge clk);
    check("add_latency", {out_valid, out, flags}, {1'b1, 16'h8000, 4'b1010});
    @(posedge clk); #1;

    issue(4'd1, 16'h0003, 16'h0005, {16'hfffe, 4'b0110});
    issue(4'd9, 16'h8001, 16'h0001, {16'hc000, 4'b0110});
    check("back_to_back_wait", last_wait, 0);
    wait_drain();

    out_ready = 1'b0;
    issue(4'd2, 16'h0100, 16'h0100, {16'h0000, 4'b1101});
    in_valid = 1'b1; opcode = 4'd0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("mul_busy", {busy, in_ready, out_valid}, 3'b100);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) check("mul_latency", {busy, out_valid}, 2'b01);
      check("stall_hold", {out, flags, in_ready}, {16'h0000, 4'b1101, 1'b0});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue(4'd3, 16'h0064, 16'h0007, {16'h000e, 4'b0000});
    check("same_cycle_accept", last_wait, 0);
    wait_drain();
    issue(4'd3, 16'h1234, 16'h0000, {16'hffff, 4'b1010});
    wait_drain();

    a = 16'($urandom); b = 16'($urandom) | 16'h1;
    issue(4'd3, a, b, model(4'd3, a, b));
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rst_mid_div", {out_valid, busy, flags, in_ready}, {1'b0, 1'b0, 4'b0000, 1'b1});
    @(posedge clk); #1;
    issue(4'd0, 16'h0001, 16'h0002, {16'h0003, 4'b0000});
    wait_drain();

    rdy_rand = 1'b1;
    for (int n = 0; n < 400; n++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 18)) : 16'($urandom);
      issue(op, a, b, model(op, a, b));
    end
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    check("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
